sync_pkt_fifo: RTL and testbench
================================

// Module: sync_pkt_fifo
// PURPOSE
//   Synchronous frame-aware FIFO for switch ingress/egress queues. Data is written speculatively
//   and becomes readable only once the frame's last beat is committed. A frame can be dropped
//   mid-write (e.g. bad FCS); a frame that overflows is auto-discarded. Adds frame count,
//   almost-full/empty thresholds and error pulses on top of the plain word FIFO.
// PARAMETERS
//   P_DATA_WIDTH    8   data bits per beat (last flag stored alongside, +1 bit)
//   P_ADDR_WIDTH    4   depth = 2**P_ADDR_WIDTH beats
//   P_FWFT          1   1: head word shown on data_o while !empty_o; 0: data_o valid 1 cycle after rd_i
//   P_AFULL_THRESH  12  afull_o when (wr_ptr - rd_ptr) >= this value
//   P_AEMPTY_THRESH 2   aempty_o when fill_level_o <= this value
// PORTS
//   clk_i         in   1               clock, rising edge
//   rst_ni        in   1               asynchronous, active-low reset
//   wr_i          in   1               write beat request
//   data_i        in   P_DATA_WIDTH    write data
//   last_i        in   1               beat is last of frame (commit)
//   drop_i        in   1               discard frame in progress
//   rd_i          in   1               read beat request
//   data_o        out  P_DATA_WIDTH    read data
//   last_o        out  1               last flag of data_o
//   empty_o       out  1               no committed beats
//   full_o        out  1               storage full (incl. uncommitted beats)
//   afull_o       out  1               almost full
//   aempty_o      out  1               almost empty
//   fill_level_o  out  P_ADDR_WIDTH+1  committed beats stored
//   frame_cnt_o   out  P_ADDR_WIDTH+1  complete frames stored
//   overflow_o    out  1               1-cycle pulse: frame auto-discarded on overflow
//   underflow_o   out  1               1-cycle pulse: rd_i while empty_o
// BEHAVIOUR
//   - Pointers wr_ptr (speculative), cmt_ptr (committed), rd_ptr; all P_ADDR_WIDTH+1 bits, natural wrap.
//   - full_o = (wr_ptr - rd_ptr) == 2**P_ADDR_WIDTH; empty_o = (cmt_ptr == rd_ptr); fill_level_o = cmt_ptr - rd_ptr.
//   - Flags derive from registered pointers: a read in the same cycle does not free space for a write
//     at full; a commit in the same cycle does not make the frame readable until the next cycle.
//   - Write FSM: IDLE -> ACTIVE on accepted beat without last; ACTIVE -> IDLE on accepted last beat
//     (cmt_ptr <= wr_ptr+1, frame_cnt+1) or drop_i (wr_ptr <= cmt_ptr). Single-beat frame commits from IDLE.
//   - wr_i while full_o: wr_ptr <= cmt_ptr, overflow_o pulses, FSM -> DISCARD. In DISCARD all beats
//     ignored; accepted-last-position beat (wr_i & last_i) returns to IDLE; no commit.
//   - drop_i has priority over wr_i in the same cycle (beat discarded); drop_i in IDLE is a no-op.
//   - Read accepted when rd_i & !empty_o: rd_ptr+1; if stored last flag set, frame_cnt-1.
//     Commit and last-read in same cycle leave frame_cnt unchanged.
//   - rd_i & empty_o: ignored, underflow_o pulses, pointers unchanged.
//   - FWFT=1: data_o/last_o = mem[rd_ptr] whenever !empty_o (0 latency). FWFT=0: registered, valid
//     cycle after accepted read, holds value otherwise.
//   - Reset (async assert, sync release): all pointers 0, FSM IDLE, empty_o=1, aempty_o=1, full_o=0,
//     afull_o=0, fill_level_o=0, frame_cnt_o=0, overflow_o=0, underflow_o=0, data_o=0, last_o=0.
//     Reset mid-frame discards everything; memory contents not cleared.
// STRUCTURE
//   - sync_fifo_pkg: wr_state_e {IDLE, ACTIVE, DISCARD}; entry struct {last, data} via parametrised typedef helper.
//   - Sub-module sdp_ram: simple dual-port RAM (1 write, 1 read port), async read for FWFT, sync read otherwise.
//   - Pointer arithmetic, FSM and flags stay in sync_pkt_fifo.
// TESTING
//   - Reset then 3-beat frame A1,A2,A3(last): empty_o=1 until cycle after A3 write; then frame_cnt_o=1, fill=3.
//   - Write 2 beats then drop_i: fill_level_o stays 0, empty_o=1; next 1-beat frame reads back correctly.
//   - 20-beat frame into depth 16: overflow_o pulses once on 17th beat, rest ignored, fill=0, frame_cnt=0.
//   - Full-rate 1-beat frames, continuous read: data order matches reference queue, frame_cnt never > 2.
//   - rd_i when empty -> underflow_o 1 cycle, rd_ptr unchanged; commit and last-read same cycle -> frame_cnt constant.
//   - Reset asserted mid-frame with 5 committed beats: all outputs at reset values immediately; next frame clean.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the frame-aware FIFO.
//   wr_state_e  : write-side frame FSM states
//   entry_width : width of one stored beat (data plus last flag)
package sync_fifo_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StActive  = 2'd1,
      StDiscard = 2'd2
   } wr_state_e;

   localparam int unsigned LP_LAST_W = 1;

   function automatic int unsigned entry_width(input int unsigned data_width);
      return data_width + LP_LAST_W;
   endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port.
//   clk_i, rst_ni          clock, async active-low reset (read register only)
//   wr_en_i/addr/data      synchronous write port
//   rd_en_i, rd_addr_i     read enable / address
//   rd_data_o              read data: combinational when P_ASYNC_RD != 0, else registered
//                          (updated on rd_en_i, held otherwise)
module sdp_ram #(
   parameter int unsigned P_WIDTH      = 9,
   parameter int unsigned P_ADDR_WIDTH = 4,
   parameter int unsigned P_ASYNC_RD   = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    wr_en_i,
   input  logic [P_ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [P_WIDTH-1:0]      wr_data_i,
   input  logic                    rd_en_i,
   input  logic [P_ADDR_WIDTH-1:0] rd_addr_i,
   output logic [P_WIDTH-1:0]      rd_data_o
);

   logic [P_WIDTH-1:0] r_mem [2**P_ADDR_WIDTH];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
   end

   if (P_ASYNC_RD != 0) begin : g_async
      // Output forced to zero when not enabled or while reset is asserted.
      assign rd_data_o = (rd_en_i && rst_ni) ? r_mem[rd_addr_i] : '0;
   end else begin : g_sync
      logic [P_WIDTH-1:0] r_rd_data;
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)      r_rd_data <= '0;
         else if (rd_en_i) r_rd_data <= r_mem[rd_addr_i];
      end
      assign rd_data_o = r_rd_data;
   end

endmodule

// File: rtl/sync_pkt_fifo.sv
// Frame-aware synchronous FIFO. Beats are written speculatively and become
// readable only when the frame's last beat commits; frames may be dropped
// mid-write or are auto-discarded on overflow.
//   clk_i, rst_ni                    clock, async active-low reset
//   wr_i, data_i, last_i, drop_i     write side
//   rd_i, data_o, last_o             read side
//   empty_o, full_o, afull_o, aempty_o, fill_level_o, frame_cnt_o   status
//   overflow_o, underflow_o          1-cycle error pulses
module sync_pkt_fifo
   import sync_fifo_pkg::*;
#(
   parameter int unsigned P_DATA_WIDTH    = 8,
   parameter int unsigned P_ADDR_WIDTH    = 4,
   parameter int unsigned P_FWFT          = 1,
   parameter int unsigned P_AFULL_THRESH  = 12,
   parameter int unsigned P_AEMPTY_THRESH = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    wr_i,
   input  logic [P_DATA_WIDTH-1:0] data_i,
   input  logic                    last_i,
   input  logic                    drop_i,
   input  logic                    rd_i,
   output logic [P_DATA_WIDTH-1:0] data_o,
   output logic                    last_o,
   output logic                    empty_o,
   output logic                    full_o,
   output logic                    afull_o,
   output logic                    aempty_o,
   output logic [P_ADDR_WIDTH:0]   fill_level_o,
   output logic [P_ADDR_WIDTH:0]   frame_cnt_o,
   output logic                    overflow_o,
   output logic                    underflow_o
);

   localparam int unsigned LP_DEPTH   = 2**P_ADDR_WIDTH;
   localparam int unsigned LP_ENTRY_W = entry_width(P_DATA_WIDTH);

   typedef logic [P_ADDR_WIDTH:0] ptr_t;
   typedef struct packed {
      logic                    last;
      logic [P_DATA_WIDTH-1:0] data;
   } entry_t;

   localparam ptr_t LP_ONE    = ptr_t'(1);
   localparam ptr_t LP_DEPTHP = ptr_t'(LP_DEPTH);
   localparam ptr_t LP_AFULL  = ptr_t'(P_AFULL_THRESH);
   localparam ptr_t LP_AEMPTY = ptr_t'(P_AEMPTY_THRESH);

   ptr_t                r_wr_ptr, r_cmt_ptr, r_rd_ptr, r_frame_cnt;
   wr_state_e           r_state;
   logic                r_overflow, r_underflow;
   // Last flags mirrored outside the RAM so frame counting works in both read modes.
   logic [LP_DEPTH-1:0] r_last_flags;

   ptr_t                  w_used, w_fill;
   logic                  w_full, w_empty, w_rd_acc, w_wr_en, w_commit, w_dec, w_ram_rd_en;
   logic [LP_ENTRY_W-1:0] w_ram_wdata, w_ram_rdata;
   entry_t                w_wr_entry, w_rd_entry;

   // Flags come from registered pointers only: no same-cycle read/write bypass.
   assign w_used   = r_wr_ptr - r_rd_ptr;
   assign w_fill   = r_cmt_ptr - r_rd_ptr;
   assign w_full   = (w_used == LP_DEPTHP);
   assign w_empty  = (r_cmt_ptr == r_rd_ptr);
   assign w_rd_acc = rd_i & ~w_empty;

   // drop_i wins over a same-cycle beat; DISCARD swallows every beat.
   assign w_wr_en  = (r_state != StDiscard) & wr_i & ~drop_i & ~w_full;
   assign w_commit = w_wr_en & last_i;
   assign w_dec    = w_rd_acc & r_last_flags[r_rd_ptr[P_ADDR_WIDTH-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr    <= '0;
         r_cmt_ptr   <= '0;
         r_rd_ptr    <= '0;
         r_frame_cnt <= '0;
         r_state     <= StIdle;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= 1'b0;
         r_underflow <= rd_i & w_empty;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + LP_ONE;

         unique case ({w_commit, w_dec})
            2'b10:   r_frame_cnt <= r_frame_cnt + LP_ONE;
            2'b01:   r_frame_cnt <= r_frame_cnt - LP_ONE;
            default: r_frame_cnt <= r_frame_cnt;
         endcase

         unique case (r_state)
            StIdle, StActive: begin
               if (drop_i) begin
                  r_wr_ptr <= r_cmt_ptr;
                  r_state  <= StIdle;
               end else if (wr_i && w_full) begin
                  r_wr_ptr   <= r_cmt_ptr;
                  r_overflow <= 1'b1;
                  // An overflowing last beat already closes the frame.
                  r_state    <= last_i ? StIdle : StDiscard;
               end else if (wr_i) begin
                  r_wr_ptr <= r_wr_ptr + LP_ONE;
                  if (last_i) begin
                     r_cmt_ptr <= r_wr_ptr + LP_ONE;
                     r_state   <= StIdle;
                  end else begin
                     r_state   <= StActive;
                  end
               end
            end
            StDiscard: begin
               if (drop_i || (wr_i && last_i)) r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr_en) r_last_flags[r_wr_ptr[P_ADDR_WIDTH-1:0]] <= last_i;
   end

   assign w_wr_entry  = '{last: last_i, data: data_i};
   assign w_ram_wdata = w_wr_entry;
   // FWFT presents the head whenever data is committed; otherwise load on accepted read.
   assign w_ram_rd_en = (P_FWFT != 0) ? ~w_empty : w_rd_acc;

   sdp_ram #(
      .P_WIDTH      (LP_ENTRY_W),
      .P_ADDR_WIDTH (P_ADDR_WIDTH),
      .P_ASYNC_RD   (P_FWFT)
   ) u_ram (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wr_en_i   (w_wr_en),
      .wr_addr_i (r_wr_ptr[P_ADDR_WIDTH-1:0]),
      .wr_data_i (w_ram_wdata),
      .rd_en_i   (w_ram_rd_en),
      .rd_addr_i (r_rd_ptr[P_ADDR_WIDTH-1:0]),
      .rd_data_o (w_ram_rdata)
   );

   assign w_rd_entry   = entry_t'(w_ram_rdata);
   assign data_o       = w_rd_entry.data;
   assign last_o       = w_rd_entry.last;
   assign empty_o      = w_empty;
   assign full_o       = w_full;
   assign afull_o      = (w_used >= LP_AFULL);
   assign aempty_o     = (w_fill <= LP_AEMPTY);
   assign fill_level_o = w_fill;
   assign frame_cnt_o  = r_frame_cnt;
   assign overflow_o   = r_overflow;
   assign underflow_o  = r_underflow;

endmodule

// File: tb/tb_sync_pkt_fifo.sv
// Directed self-checking bench for sync_pkt_fifo (depth 16, FWFT).
module tb_sync_pkt_fifo;

   logic       clk_i, rst_ni, wr_i, last_i, drop_i, rd_i;
   logic [7:0] data_i, data_o;
   logic       last_o, empty_o, full_o, afull_o, aempty_o, overflow_o, underflow_o;
   logic [4:0] fill_level_o, frame_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] q[$];
   logic [7:0] exp_d;

   sync_pkt_fifo #(
      .P_DATA_WIDTH    (8),
      .P_ADDR_WIDTH    (4),
      .P_FWFT          (1),
      .P_AFULL_THRESH  (12),
      .P_AEMPTY_THRESH (2)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .wr_i         (wr_i),
      .data_i       (data_i),
      .last_i       (last_i),
      .drop_i       (drop_i),
      .rd_i         (rd_i),
      .data_o       (data_o),
      .last_o       (last_o),
      .empty_o      (empty_o),
      .full_o       (full_o),
      .afull_o      (afull_o),
      .aempty_o     (aempty_o),
      .fill_level_o (fill_level_o),
      .frame_cnt_o  (frame_cnt_o),
      .overflow_o   (overflow_o),
      .underflow_o  (underflow_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".empty"}, 32'(empty_o), 1);
      chk({tag, ".aempty"}, 32'(aempty_o), 1);
      chk({tag, ".full"}, 32'(full_o), 0);
      chk({tag, ".afull"}, 32'(afull_o), 0);
      chk({tag, ".fill"}, 32'(fill_level_o), 0);
      chk({tag, ".frames"}, 32'(frame_cnt_o), 0);
      chk({tag, ".ovf"}, 32'(overflow_o), 0);
      chk({tag, ".unf"}, 32'(underflow_o), 0);
      chk({tag, ".data"}, 32'(data_o), 0);
      chk({tag, ".last"}, 32'(last_o), 0);
   endtask

   task automatic beat(input logic [7:0] d, input logic l);
      wr_i = 1'b1; data_i = d; last_i = l;
      step();
      wr_i = 1'b0; last_i = 1'b0;
   endtask

   initial begin
      rst_ni = 1'b0; wr_i = 1'b0; data_i = '0; last_i = 1'b0; drop_i = 1'b0; rd_i = 1'b0;
      #3;
      chk_reset("rst");
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();

      // 3-beat frame: invisible until the commit edge.
      beat(8'hA1, 1'b0);
      chk("a1.empty", 32'(empty_o), 1);
      beat(8'hA2, 1'b0);
      chk("a2.empty", 32'(empty_o), 1);
      chk("a2.fill", 32'(fill_level_o), 0);
      beat(8'hA3, 1'b1);
      chk("a3.empty", 32'(empty_o), 0);
      chk("a3.frames", 32'(frame_cnt_o), 1);
      chk("a3.fill", 32'(fill_level_o), 3);
      chk("a3.aempty", 32'(aempty_o), 0);
      chk("a3.data", 32'(data_o), 32'hA1);
      chk("a3.last", 32'(last_o), 0);
      rd_i = 1'b1;
      step();
      chk("rd1.data", 32'(data_o), 32'hA2);
      chk("rd1.fill", 32'(fill_level_o), 2);
      chk("rd1.aempty", 32'(aempty_o), 1);
      step();
      chk("rd2.data", 32'(data_o), 32'hA3);
      chk("rd2.last", 32'(last_o), 1);
      chk("rd2.frames", 32'(frame_cnt_o), 1);
      step();
      rd_i = 1'b0;
      chk("rd3.frames", 32'(frame_cnt_o), 0);
      chk("rd3.empty", 32'(empty_o), 1);

      // Drop mid-frame; drop wins over a same-cycle beat.
      beat(8'hB1, 1'b0);
      wr_i = 1'b1; data_i = 8'hB2; last_i = 1'b1; drop_i = 1'b1;
      step();
      wr_i = 1'b0; last_i = 1'b0; drop_i = 1'b0;
      chk("drop.fill", 32'(fill_level_o), 0);
      chk("drop.empty", 32'(empty_o), 1);
      chk("drop.frames", 32'(frame_cnt_o), 0);
      beat(8'h3C, 1'b1);
      chk("c.data", 32'(data_o), 32'h3C);
      chk("c.last", 32'(last_o), 1);
      chk("c.fill", 32'(fill_level_o), 1);
      rd_i = 1'b1;
      step();
      rd_i = 1'b0;
      chk("c.rd_empty", 32'(empty_o), 1);

      // 20-beat frame into 16 entries: overflow on beat 17, remainder swallowed.
      for (int i = 1; i <= 20; i++) begin
         beat(8'(i), (i == 20));
         chk($sformatf("ovf.b%0d", i), 32'(overflow_o), 32'(i == 17));
         if (i == 11) chk("ovf.afull11", 32'(afull_o), 0);
         if (i == 12) chk("ovf.afull12", 32'(afull_o), 1);
         if (i == 15) chk("ovf.full15", 32'(full_o), 0);
         if (i == 16) chk("ovf.full16", 32'(full_o), 1);
         if (i == 17) chk("ovf.full17", 32'(full_o), 0);
      end
      chk("ovf.fill", 32'(fill_level_o), 0);
      chk("ovf.frames", 32'(frame_cnt_o), 0);
      chk("ovf.empty", 32'(empty_o), 1);
      beat(8'h5A, 1'b1);
      chk("post_ovf.data", 32'(data_o), 32'h5A);
      chk("post_ovf.frames", 32'(frame_cnt_o), 1);
      rd_i = 1'b1;
      step();
      rd_i = 1'b0;

      // Full-rate 1-beat frames with continuous reads.
      for (int i = 0; i < 10; i++) begin
         wr_i = 1'b1; data_i = 8'h40 + 8'(i); last_i = 1'b1; rd_i = 1'b1;
         chk($sformatf("stream.empty%0d", i), 32'(empty_o), 32'(q.size() == 0));
         if (q.size() != 0) begin
            exp_d = q.pop_front();
            chk($sformatf("stream.data%0d", i), 32'(data_o), 32'(exp_d));
         end
         step();
         q.push_back(8'h40 + 8'(i));
         chk($sformatf("stream.frames%0d", i), 32'(frame_cnt_o), 32'(q.size()));
         chk($sformatf("stream.unf%0d", i), 32'(underflow_o), 32'(i == 0));
      end
      wr_i = 1'b0; last_i = 1'b0;
      exp_d = q.pop_front();
      chk("stream.tail", 32'(data_o), 32'(exp_d));
      step();
      rd_i = 1'b0;
      chk("stream.empty_end", 32'(empty_o), 1);
      chk("stream.frames_end", 32'(frame_cnt_o), 0);

      // Underflow: pulse for one cycle, nothing moves.
      rd_i = 1'b1;
      step();
      rd_i = 1'b0;
      chk("unf.pulse", 32'(underflow_o), 1);
      chk("unf.fill", 32'(fill_level_o), 0);
      step();
      chk("unf.clear", 32'(underflow_o), 0);
      beat(8'h9E, 1'b1);
      chk("unf.next_data", 32'(data_o), 32'h9E);
      rd_i = 1'b1;
      step();
      rd_i = 1'b0;

      // Reset mid-frame with 5 committed beats plus an open frame.
      for (int i = 1; i <= 5; i++) beat(8'h60 + 8'(i), (i == 5));
      beat(8'h66, 1'b0);
      beat(8'h67, 1'b0);
      chk("mid.fill", 32'(fill_level_o), 5);
      chk("mid.frames", 32'(frame_cnt_o), 1);
      chk("mid.data", 32'(data_o), 32'h61);
      #2;
      rst_ni = 1'b0;
      #1;
      chk_reset("mid_rst");
      @(negedge clk_i);
      rst_ni = 1'b1;
      step();
      beat(8'h77, 1'b1);
      chk("after.data", 32'(data_o), 32'h77);
      chk("after.last", 32'(last_o), 1);
      chk("after.fill", 32'(fill_level_o), 1);
      chk("after.frames", 32'(frame_cnt_o), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
